// File: rtl/gpu_launch_ctrl.sv
// gpu_launch_ctrl: sequences gpu reset, DCR write and start for one kernel launch, then reports run cycles.
module gpu_launch_ctrl #(
  parameter int CYCLE_BITS     = 32,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int RESET_CYCLES   = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [7:0]            cmd_thread_count,
  output logic                  gpu_reset,
  output logic                  device_control_write_enable,
  output logic [7:0]            device_control_data,
  output logic                  start,
  input  logic                  done,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [CYCLE_BITS-1:0] rsp_cycles,
  output logic                  rsp_timeout,
  output logic                  busy
);
  typedef enum logic [2:0] {IDLE, GRST, DCR, RUN, RSP} state_t;
  localparam logic [CYCLE_BITS-1:0] RST_LEN = CYCLE_BITS'(RESET_CYCLES);
  localparam logic [CYCLE_BITS-1:0] TMO_LEN = CYCLE_BITS'(TIMEOUT_CYCLES);
  state_t state, state_d;
  logic [CYCLE_BITS-1:0] cnt, cnt_d, rsp_cycles_d;
  logic [7:0] thr, thr_d, dcr_data_d;
  logic rsp_timeout_d, accept, tmo_hit;
  logic cmd_ready_d, gpu_reset_d, dcr_we_d, start_d, rsp_valid_d, busy_d;
  assign accept  = cmd_valid && cmd_ready;
  assign tmo_hit = (TIMEOUT_CYCLES != 0) && (cnt == TMO_LEN);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state                       <= IDLE;
      cnt                         <= '0;
      thr                         <= '0;
      cmd_ready                   <= 1'b1;
      gpu_reset                   <= 1'b0;
      device_control_write_enable <= 1'b0;
      device_control_data         <= '0;
      start                       <= 1'b0;
      rsp_valid                   <= 1'b0;
      rsp_cycles                  <= '0;
      rsp_timeout                 <= 1'b0;
      busy                        <= 1'b0;
    end else begin
      state                       <= state_d;
      cnt                         <= cnt_d;
      thr                         <= thr_d;
      cmd_ready                   <= cmd_ready_d;
      gpu_reset                   <= gpu_reset_d;
      device_control_write_enable <= dcr_we_d;
      device_control_data         <= dcr_data_d;
      start                       <= start_d;
      rsp_valid                   <= rsp_valid_d;
      rsp_cycles                  <= rsp_cycles_d;
      rsp_timeout                 <= rsp_timeout_d;
      busy                        <= busy_d;
    end
  // cnt restarts at 1 on every state entry and saturates, serving both GRST length and run cycles
  always_comb begin
    state_d       = state;
    rsp_cycles_d  = rsp_cycles;
    rsp_timeout_d = rsp_timeout;
    case (state)
      IDLE: if (accept) begin
        state_d       = (cmd_thread_count == 8'd0) ? RSP : GRST;
        rsp_cycles_d  = '0;
        rsp_timeout_d = 1'b0;
      end
      GRST: state_d = (cnt == RST_LEN) ? DCR : GRST;
      DCR:  state_d = RUN;
      RUN:  if (done || tmo_hit) begin
        state_d       = RSP;
        rsp_cycles_d  = cnt;
        rsp_timeout_d = !done;
      end
      RSP:  state_d = rsp_ready ? IDLE : RSP;
      default: state_d = IDLE;
    endcase
    cnt_d = (state_d != state) ? CYCLE_BITS'(1) : (&cnt ? cnt : cnt + 1'b1);
    thr_d = accept ? cmd_thread_count : thr;
  end
  always_comb begin
    cmd_ready_d = state_d == IDLE;
    gpu_reset_d = state_d == GRST;
    dcr_we_d    = state_d == DCR;
    dcr_data_d  = (state_d == DCR) ? thr_d : 8'd0;
    start_d     = state_d == RUN;
    rsp_valid_d = state_d == RSP;
    busy_d      = state_d != IDLE;
  end
endmodule

// File: tb/tb_gpu_launch_ctrl.sv
// tb_gpu_launch_ctrl: scoreboard bench with a simple gpu model driving done after N start cycles.
module tb_gpu_launch_ctrl;
  logic clk = 0, reset_n = 1, cmd_valid = 0, rsp_ready = 0, spur = 0, run_hit = 0;
  logic cmd_ready, gpu_reset, dcr_we, start, done, rsp_valid, rsp_timeout, busy;
  logic [7:0] cmd_thread_count = 0, dcr_data, dcr_last = 0;
  logic [31:0] rsp_cycles;
  int total = 0, bad = 0, n_grst = 0, n_dcr = 0, n_start = 0, sc = 0, run_len = 0;
  typedef struct {logic [31:0] cyc; logic tmo;} rsp_t;
  rsp_t exp_q[$];
  always #5 clk = ~clk;
  assign done = spur || run_hit;
  gpu_launch_ctrl #(.CYCLE_BITS(32), .TIMEOUT_CYCLES(50), .RESET_CYCLES(2)) dut (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_thread_count(cmd_thread_count), .gpu_reset(gpu_reset),
    .device_control_write_enable(dcr_we), .device_control_data(dcr_data), .start(start),
    .done(done), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_cycles(rsp_cycles),
    .rsp_timeout(rsp_timeout), .busy(busy)
  );
  // gpu model: done rises on the run_len-th cycle that start is seen high
  always @(negedge clk) begin
    if (gpu_reset) n_grst++;
    if (dcr_we) begin
      n_dcr++;
      dcr_last = dcr_data;
    end
    if (start) begin
      n_start++;
      sc++;
    end else sc = 0;
    run_hit = start && run_len != 0 && sc == run_len;
  end
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask
  task automatic launch(input int cnt, input int rl, input int hold, input bit sp);
    int g0, d0, s0, lat, ec;
    bit et;
    rsp_t r;
    logic [31:0] c0;
    et = cnt != 0 && (rl == 0 || rl > 50);
    ec = cnt == 0 ? 0 : (et ? 50 : rl);
    exp_q.push_back(rsp_t'{32'(ec), et});
    run_len = rl;
    @(negedge clk) #1;
    g0 = n_grst; d0 = n_dcr; s0 = n_start;
    cmd_valid = 1; cmd_thread_count = 8'(cnt); spur = sp;
    @(negedge clk) #1;
    cmd_valid = 0;
    chk("accept_busy", busy, 1);
    lat = 1;
    while (!rsp_valid && lat < 300) begin
      if (start) spur = 0;
      @(negedge clk) #1;
      lat++;
    end
    spur = 0;
    chk("rsp_latency", lat, cnt == 0 ? 1 : 4 + ec);
    c0 = rsp_cycles;
    repeat (hold) begin
      chk("bp_cmd_ready", cmd_ready, 0);
      cmd_valid = 1; cmd_thread_count = 8'd3;
      @(negedge clk) #1;
      cmd_valid = 0;
      chk("bp_stable", rsp_cycles, c0);
      chk("bp_valid", rsp_valid, 1);
    end
    r = exp_q.pop_front();
    chk("rsp_cycles", rsp_cycles, r.cyc);
    chk("rsp_timeout", rsp_timeout, r.tmo);
    rsp_ready = 1;
    @(negedge clk) #1;
    rsp_ready = 0;
    chk("rsp_drop", rsp_valid, 0);
    chk("idle_ready", cmd_ready, 1);
    chk("grst_cycles", n_grst - g0, cnt != 0 ? 2 : 0);
    chk("dcr_writes", n_dcr - d0, cnt != 0 ? 1 : 0);
    chk("start_cycles", n_start - s0, ec);
    if (cnt != 0) chk("dcr_data", dcr_last, cnt);
  endtask
  initial begin
    #1 reset_n = 0;
    #20;
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_start", start, 0);
    chk("rst_gpu_reset", gpu_reset, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    @(negedge clk) #1 reset_n = 1;
    launch(8, 20, 0, 0);
    launch(0, 5, 0, 0);
    launch(8, 0, 0, 0);
    launch(4, 10, 0, 0);
    launch(6, 7, 5, 0);
    launch(2, 1, 0, 1);
    launch(5, 50, 0, 0);
    run_len = 0;
    @(negedge clk) #1;
    cmd_valid = 1; cmd_thread_count = 8'd8;
    @(negedge clk) #1;
    cmd_valid = 0;
    repeat (10) @(negedge clk) #1;
    chk("pre_rst_start", start, 1);
    #2 reset_n = 0;
    #1;
    chk("arst_start", start, 0);
    chk("arst_busy", busy, 0);
    chk("arst_cmd_ready", cmd_ready, 1);
    chk("arst_gpu_reset", gpu_reset, 0);
    @(negedge clk) #1 reset_n = 1;
    launch(8, 20, 0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
